// File: rtl/reset_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// reset_seq_pkg
// Shared definitions for the reset sequencer:
//   - state_e      : sequencer FSM states (HOLD -> STRETCH -> RUN)
//   - CAUSE_*      : bit positions inside the sticky cause register
//   - cnt_width()  : width of the stretch counter for a given stretch length
// -----------------------------------------------------------------------------
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STRETCH = 2'd1,
    RUN     = 2'd2
  } state_e;

  localparam int CAUSE_POR = 0;
  localparam int CAUSE_SW  = 1;
  localparam int CAUSE_WDT = 2;

  // Counter must hold values up to STRETCH_CYCLES.
  function automatic int cnt_width(input int stretch_cycles);
    return $clog2(stretch_cycles + 1);
  endfunction

endpackage

// File: rtl/reset_sequencer_sync_chain.sv
// -----------------------------------------------------------------------------
// reset_sync_chain
// Deassertion synchronizer for the power-on/pad reset. All stages clear
// asynchronously on rst; once rst is low, ones ripple in from stage 0 and the
// last stage reports that the release has been synchronized to clk.
// Ports:
//   clk       in  1  clock
//   rst       in  1  asynchronous active-high clear
//   sync_out  out 1  last synchronizer stage
// -----------------------------------------------------------------------------
module reset_sync_chain #(
  parameter int SYNC_STAGES = 3
) (
  input  logic clk,
  input  logic rst,
  output logic sync_out
);

  // Synchronizer flops must stay a plain shift chain: no retiming, no copies.
  (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE", KEEP = "TRUE" *)
  logic [SYNC_STAGES-1:0] chain_q;
  logic [SYNC_STAGES-1:0] chain_d;

  // Next-state: shift a constant one into stage 0.
  always_comb begin
    chain_d = {chain_q[SYNC_STAGES-2:0], 1'b1};
  end

  // Chain register, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign sync_out = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
// Upstream reset source for async-reset register banks. rst_out is set
// asynchronously by rst and released synchronously to clk after the
// synchronizer chain has filled and a minimum stretch has elapsed. Software
// and watchdog requests (already synchronous) re-enter the stretch directly.
// A sticky cause register records which sources have fired.
// Ports:
//   clk          in  1  clock
//   rst          in  1  asynchronous active-high power-on/pad reset
//   sw_rst_req   in  1  software reset request (level, sampled each edge)
//   wdt_rst_req  in  1  watchdog reset request (level, sampled each edge)
//   cause_clr    in  1  clear cause[2:1]; also cause[0] when in RUN
//   rst_out      out 1  registered reset to downstream logic, active-high
//   rst_done     out 1  one-cycle pulse in the first cycle rst_out is low
//   cause        out 3  sticky cause {wdt, sw, por}
// -----------------------------------------------------------------------------
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES    = 3,
  parameter int STRETCH_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_rst_req,
  input  logic       wdt_rst_req,
  input  logic       cause_clr,
  output logic       rst_out,
  output logic       rst_done,
  output logic [2:0] cause
);

  localparam int CW = cnt_width(STRETCH_CYCLES);

  // Load value for a request-triggered stretch: rst_out stays high for
  // STRETCH_CYCLES cycles starting at the request edge.
  localparam logic [CW-1:0] CNT_LOAD = CW'(STRETCH_CYCLES - 1);

  // After POR the cycle in which sync_out first reads 1 is already the first
  // stretch cycle, so the POR path loads one less (or skips STRETCH entirely
  // for a single-cycle stretch). This keeps rst_out falling exactly
  // SYNC_STAGES+STRETCH_CYCLES edges after rst is released.
  localparam bit            POR_DIRECT   = (STRETCH_CYCLES == 1);
  localparam logic [CW-1:0] CNT_LOAD_POR = CW'((STRETCH_CYCLES >= 2) ? (STRETCH_CYCLES - 2) : 0);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rst_out_q, rst_out_d;
  logic            rst_done_q, rst_done_d;
  logic [2:0]      cause_q, cause_d;
  logic            sync_done;
  logic            req;

  reset_sync_chain #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_chain (
    .clk      (clk),
    .rst      (rst),
    .sync_out (sync_done)
  );

  // Sequencer next-state, stretch counter and rst_out next value.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rst_out_d = rst_out_q;
    req       = sw_rst_req | wdt_rst_req;

    case (state_q)
      HOLD: begin
        // Requests here only record cause; the POR sequence runs unchanged.
        if (sync_done) begin
          if (POR_DIRECT) begin
            state_d   = RUN;
            rst_out_d = 1'b0;
          end else begin
            state_d   = STRETCH;
            cnt_d     = CNT_LOAD_POR;
            rst_out_d = 1'b1;
          end
        end else begin
          rst_out_d = 1'b1;
        end
      end
      STRETCH: begin
        if (req) begin
          cnt_d     = CNT_LOAD;
          rst_out_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d   = RUN;
          rst_out_d = 1'b0;
        end else begin
          cnt_d     = cnt_q - CW'(1);
          rst_out_d = 1'b1;
        end
      end
      RUN: begin
        if (req) begin
          state_d   = STRETCH;
          cnt_d     = CNT_LOAD;
          rst_out_d = 1'b1;
        end else begin
          rst_out_d = 1'b0;
        end
      end
      default: begin
        state_d   = HOLD;
        cnt_d     = '0;
        rst_out_d = 1'b1;
      end
    endcase

    // rst_out only falls on entry to RUN, so a falling edge marks completion.
    rst_done_d = rst_out_q & ~rst_out_d;
  end

  // Sticky cause bits; a set in the same cycle as a clear takes priority.
  always_comb begin
    cause_d            = cause_q;
    cause_d[CAUSE_POR] = cause_q[CAUSE_POR] & ~(cause_clr & (state_q == RUN));
    cause_d[CAUSE_SW]  = sw_rst_req  | (cause_q[CAUSE_SW]  & ~cause_clr);
    cause_d[CAUSE_WDT] = wdt_rst_req | (cause_q[CAUSE_WDT] & ~cause_clr);
  end

  // State, counter, cause and output registers; rst abandons everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HOLD;
      cnt_q      <= '0;
      rst_out_q  <= 1'b1;
      rst_done_q <= 1'b0;
      cause_q    <= 3'b001;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rst_out_q  <= rst_out_d;
      rst_done_q <= rst_done_d;
      cause_q    <= cause_d;
    end
  end

  assign rst_out  = rst_out_q;
  assign rst_done = rst_done_q;
  assign cause    = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
// Directed bench for reset_sequencer: a default-parameter instance (dut) and a
// minimum-parameter instance (dut_min, SYNC_STAGES=2, STRETCH_CYCLES=1).
// Edge n below means the n-th rising clk edge after rst is released; outputs
// are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst, sw_rst_req, wdt_rst_req, cause_clr;
  logic       rst_out, rst_done;
  logic [2:0] cause;

  logic       rst_b, sw_b, wdt_b, clr_b;
  logic       rst_out_b, rst_done_b;
  logic [2:0] cause_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .SYNC_STAGES    (3),
    .STRETCH_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sw_rst_req  (sw_rst_req),
    .wdt_rst_req (wdt_rst_req),
    .cause_clr   (cause_clr),
    .rst_out     (rst_out),
    .rst_done    (rst_done),
    .cause       (cause)
  );

  reset_sequencer #(
    .SYNC_STAGES    (2),
    .STRETCH_CYCLES (1)
  ) dut_min (
    .clk         (clk),
    .rst         (rst_b),
    .sw_rst_req  (sw_b),
    .wdt_rst_req (wdt_b),
    .cause_clr   (clr_b),
    .rst_out     (rst_out_b),
    .rst_done    (rst_done_b),
    .cause       (cause_b)
  );

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // n further edges with rst_out still high and no done pulse.
  task automatic expect_high(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      check({tag, "_rst_out_high"}, {2'b00, rst_out}, 3'b001);
      check({tag, "_rst_done_low"}, {2'b00, rst_done}, 3'b000);
    end
  endtask

  // Next edge releases rst_out with a done pulse; the edge after ends the pulse.
  task automatic expect_fall(input string tag);
    tick();
    check({tag, "_rst_out_fall"}, {2'b00, rst_out}, 3'b000);
    check({tag, "_rst_done_pulse"}, {2'b00, rst_done}, 3'b001);
    tick();
    check({tag, "_rst_out_low"}, {2'b00, rst_out}, 3'b000);
    check({tag, "_rst_done_end"}, {2'b00, rst_done}, 3'b000);
  endtask

  initial begin
    rst = 1'b1; sw_rst_req = 1'b0; wdt_rst_req = 1'b0; cause_clr = 1'b0;
    rst_b = 1'b1; sw_b = 1'b0; wdt_b = 1'b0; clr_b = 1'b0;
    #1;
    check("reset_rst_out", {2'b00, rst_out}, 3'b001);
    check("reset_rst_done", {2'b00, rst_done}, 3'b000);
    check("reset_cause", cause, 3'b001);

    // 1: POR, rst held for 5 cycles, rst_out falls at edge 19.
    repeat (5) tick();
    check("por_held_rst_out", {2'b00, rst_out}, 3'b001);
    rst = 1'b0;
    expect_high(18, "por");
    expect_fall("por");
    check("por_cause", cause, 3'b001);

    // 2: software reset in RUN, high for edges k..k+15, falls at k+16.
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    check("sw_rise", {2'b00, rst_out}, 3'b001);
    check("sw_cause", cause, 3'b011);
    expect_high(15, "sw");
    expect_fall("sw");
    check("sw_cause_after", cause, 3'b011);

    // 3: watchdog at k, software at k+10 restarts the stretch -> falls at k+26.
    wdt_rst_req = 1'b1;
    tick();
    wdt_rst_req = 1'b0;
    check("wdt_rise", {2'b00, rst_out}, 3'b001);
    expect_high(9, "restart_a");
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    check("restart_sw_edge", {2'b00, rst_out}, 3'b001);
    expect_high(15, "restart_b");
    expect_fall("restart");
    check("restart_cause", cause, 3'b111);

    // 4: clear in RUN clears all; set beats clear in the same cycle.
    cause_clr = 1'b1;
    tick();
    cause_clr = 1'b0;
    check("clr_run_cause", cause, 3'b000);
    check("clr_run_rst_out", {2'b00, rst_out}, 3'b000);
    sw_rst_req = 1'b1; wdt_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    check("race_setup_cause", cause, 3'b110);
    cause_clr = 1'b1;
    tick();
    wdt_rst_req = 1'b0;
    check("race_cause", cause, 3'b100);
    tick();
    cause_clr = 1'b0;
    check("clr_alone_cause", cause, 3'b000);
    expect_high(14, "race");
    expect_fall("race");

    // 5: rst asserted between edges during STRETCH, then full sequence again.
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    check("mid_pre_cause", cause, 3'b010);
    expect_high(4, "mid_pre");
    #3;
    rst = 1'b1;
    #1;
    check("mid_async_rst_out", {2'b00, rst_out}, 3'b001);
    check("mid_async_cause", cause, 3'b001);
    check("mid_async_rst_done", {2'b00, rst_done}, 3'b000);
    repeat (3) begin
      tick();
      check("mid_held_rst_out", {2'b00, rst_out}, 3'b001);
    end
    rst = 1'b0;
    cause_clr = 1'b1;
    tick();
    cause_clr = 1'b0;
    check("hold_clr_keeps_por", cause, 3'b001);
    check("hold_e1_rst_out", {2'b00, rst_out}, 3'b001);
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    check("hold_req_cause", cause, 3'b011);
    check("hold_e2_rst_out", {2'b00, rst_out}, 3'b001);
    expect_high(16, "mid_post");
    expect_fall("mid_post");

    // 6: minimum parameters, rst_out falls at edge 3; request gives 1-cycle pulse.
    rst_b = 1'b0;
    tick();
    check("min_e1_rst_out", {2'b00, rst_out_b}, 3'b001);
    tick();
    check("min_e2_rst_out", {2'b00, rst_out_b}, 3'b001);
    check("min_e2_rst_done", {2'b00, rst_done_b}, 3'b000);
    tick();
    check("min_e3_rst_out", {2'b00, rst_out_b}, 3'b000);
    check("min_e3_rst_done", {2'b00, rst_done_b}, 3'b001);
    tick();
    check("min_e4_rst_done", {2'b00, rst_done_b}, 3'b000);
    check("min_por_cause", cause_b, 3'b001);
    wdt_b = 1'b1;
    tick();
    wdt_b = 1'b0;
    check("min_req_rst_out", {2'b00, rst_out_b}, 3'b001);
    check("min_req_cause", cause_b, 3'b101);
    tick();
    check("min_req_fall", {2'b00, rst_out_b}, 3'b000);
    check("min_req_done", {2'b00, rst_done_b}, 3'b001);
    tick();
    check("min_req_done_end", {2'b00, rst_done_b}, 3'b000);
    check("min_req_low", {2'b00, rst_out_b}, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
